// File: rtl/kamacore_dmem_responder.sv
// rtl/kamacore_dmem_responder.sv - data-memory responder for the core's MEM-stage load/store port
// Optional access-fault checking is enabled by defining KAMACORE_DMEM_ERR_EN.
module kamacore_dmem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [31:0]             req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  lat_we;
    logic [31:0]           lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [NB-1:0]         lat_be;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic                  accept;
    logic                  go;
    logic                  acc_we;
    logic [31:0]           acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [NB-1:0]         acc_be;
    logic [AW-1:0]         acc_idx;
    logic                  fault;
    logic                  unused_addr;

    assign accept = req_valid && req_ready;

    // With no wait states the access happens on the accept edge, so it must use the live request.
    assign go = ((state == IDLE) && accept && (WAIT_STATES == 0))
             || ((state == WAIT) && (cnt == 4'd0));

    assign acc_we    = (state == IDLE) ? req_we    : lat_we;
    assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign acc_be    = (state == IDLE) ? req_be    : lat_be;
    assign acc_idx   = acc_addr[AW+1:2];

    assign unused_addr = ^{acc_addr[31:AW+2], acc_addr[1:0]};

`ifdef KAMACORE_DMEM_ERR_EN
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    logic [1:0]    off;
    logic [NB-1:0] be_byte;
    logic [NB-1:0] be_half;

    always_comb begin
        off     = acc_addr[1:0];
        be_byte = NB'(1) << off;
        be_half = NB'(3) << off;
        fault   = 1'b0;
        if ({1'b0, acc_addr} >= LIMIT) begin
            fault = 1'b1;
        end else if (!acc_we && (off != 2'd0)) begin
            fault = 1'b1;
        end else if (acc_we && (acc_be != '0)
                     && !((acc_be == be_byte)
                          || (!off[0] && (acc_be == be_half))
                          || ((off == 2'd0) && (acc_be == {NB{1'b1}})))) begin
            fault = 1'b1;
        end
    end
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (go && acc_we && !fault) begin
            for (int i = 0; i < NB; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][i*8 +: 8] <= acc_wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        if (WAIT_STATES != 0) begin
                            cnt   <= 4'(WAIT_STATES - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (go) begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_err   <= fault;
                rsp_rdata <= (acc_we || fault) ? '0 : mem[acc_idx];
            end
        end
    end
endmodule

// File: tb/tb_kamacore_dmem_responder.sv
// tb/tb_kamacore_dmem_responder.sv - scoreboard bench for kamacore_dmem_responder
// Three instances cover WAIT_STATES = 1, 0 and 4.
module tb_kamacore_dmem_responder;
    logic        clk = 1'b0;
    logic        rst       [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    logic [31:0] model [3][1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        kamacore_dmem_responder #(
            .DATA_WIDTH (32),
            .DEPTH_WORDS(1024),
            .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 4))
        ) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we   (req_we[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_be   (req_be[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g])
        );
    end

    function automatic int ws(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 4);
    endfunction

    function automatic logic bench_fault(input logic we, input logic [31:0] addr, input logic [3:0] be);
`ifdef KAMACORE_DMEM_ERR_EN
        if (addr >= 32'd4096) return 1'b1;
        if (!we) return addr[1:0] != 2'd0;
        if (be == 4'h0) return 1'b0;
        case ({addr[1:0], be})
            6'b00_0001, 6'b00_0011, 6'b00_1111,
            6'b01_0010, 6'b10_0100, 6'b10_1100, 6'b11_1000: return 1'b0;
            default: return 1'b1;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    // Called #1 after a clock edge; returns #1 after the response handshake edge.
    task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int hold,
                          output int acc_cyc, output logic [31:0] got);
        int          waited;
        logic        rdy;
        logic [31:0] r0;
        logic        e0;
        logic [31:0] exp_r;
        logic        exp_e;
        logic [9:0]  idx;
        exp_t        ex;
        got          = 32'hx;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        req_valid[d] = 1'b1;
        rsp_ready[d] = (hold == 0);
        acc_cyc      = -1;
        waited       = 0;
        while (acc_cyc < 0 && waited < 50) begin
            rdy = req_ready[d];
            @(posedge clk);
            #1;
            if (rdy) acc_cyc = cyc;
            waited++;
        end
        req_valid[d] = 1'b0;
        req_we[d]    = ~we;
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        req_be[d]    = 4'($urandom);
        checks++;
        if (acc_cyc < 0) begin
            failures++;
            $display("FAIL accept_timeout dut=%0d addr=%h: not accepted within 50 cycles", d, addr);
            return;
        end
        exp_e = bench_fault(we, addr, be);
        idx   = addr[11:2];
        if (we) begin
            exp_r = 32'h0;
            if (!exp_e) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) model[d][idx][i*8 +: 8] = wdata[i*8 +: 8];
                end
            end
        end else begin
            exp_r = exp_e ? 32'h0 : model[d][idx];
        end
        sb.push_back('{exp_r, exp_e});
        waited = 0;
        while (!rsp_valid[d] && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checks++;
        if (!rsp_valid[d]) begin
            failures++;
            $display("FAIL rsp_timeout dut=%0d addr=%h: no rsp_valid within 50 cycles", d, addr);
            void'(sb.pop_back());
            return;
        end
        checks++;
        if (waited !== ws(d)) begin
            failures++;
            $display("FAIL latency dut=%0d: got %0d cycles after accept, expected %0d", d, waited, ws(d));
        end
        r0 = rsp_rdata[d];
        e0 = rsp_err[d];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== r0 || rsp_err[d] !== e0 || req_ready[d] !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold dut=%0d cycle=%0d: valid=%b rdata=%h ready=%b, expected valid=1 rdata=%h ready=0",
                         d, i, rsp_valid[d], rsp_rdata[d], req_ready[d], r0);
            end
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
        checks++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            failures++;
            $display("FAIL post_handshake dut=%0d: rsp_valid=%b req_ready=%b, expected 0 and 1",
                     d, rsp_valid[d], req_ready[d]);
        end
        ex  = sb.pop_front();
        got = r0;
        checks++;
        if (r0 !== ex.rdata || e0 !== ex.err) begin
            failures++;
            $display("FAIL response dut=%0d addr=%h we=%b: rdata=%h err=%b, expected rdata=%h err=%b",
                     d, addr, we, r0, e0, ex.rdata, ex.err);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b0; req_valid[d] = 1'b0; rsp_ready[d] = 1'b0;
            req_we[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0; req_be[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 || rsp_err[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_state dut=%0d: ready=%b valid=%b rdata=%h err=%b, expected all 0",
                         d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
            end
            rst[d] = 1'b1;
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (req_ready[d] !== 1'b0) begin
                failures++;
                $display("FAIL ready_before_clk dut=%0d: req_ready=%b, expected 0", d, req_ready[d]);
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1) begin
                failures++;
                $display("FAIL ready_after_release dut=%0d: req_ready=%b, expected 1", d, req_ready[d]);
            end
        end
    endtask

    task automatic test_store_load();
        int ac; logic [31:0] got;
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, ac, got);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, ac, got);
        checks++;
        if (got !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL store_load_word: rdata=%h, expected deadbeef", got);
        end
    endtask

    task automatic test_byte_lane();
        int ac; logic [31:0] got;
        do_req(0, 1'b1, 32'h12, 32'h00AB0000, 4'h4, 0, ac, got);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, ac, got);
        checks++;
        if (got !== 32'hDEABBEEF) begin
            failures++;
            $display("FAIL byte_lane: rdata=%h, expected deabbeef", got);
        end
        do_req(0, 1'b1, 32'h14, 32'h5555AAAA, 4'h0, 0, ac, got);
        do_req(0, 1'b1, 32'h14, 32'h12340000, 4'hC, 0, ac, got);
    endtask

    task automatic test_backpressure();
        int ac; logic [31:0] got;
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, ac, got);
        do_req(2, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, 3, ac, got);
        do_req(2, 1'b0, 32'h30, 32'h0, 4'h0, 2, ac, got);
    endtask

    task automatic test_back_to_back();
        int a0, a1; logic [31:0] got;
        do_req(1, 1'b1, 32'h40, 32'hA5A5_5A5A, 4'hF, 0, a0, got);
        do_req(1, 1'b1, 32'h42, 32'h7788_0000, 4'hC, 0, a0, got);
        do_req(1, 1'b0, 32'h40, 32'h0, 4'h0, 0, a0, got);
        do_req(1, 1'b0, 32'h40, 32'h0, 4'h0, 0, a1, got);
        checks++;
        if (a1 - a0 !== 2) begin
            failures++;
            $display("FAIL back_to_back_spacing: second accept %0d cycles after first, expected 2", a1 - a0);
        end
        checks++;
        if (got !== 32'h7788_5A5A) begin
            failures++;
            $display("FAIL half_store: rdata=%h, expected 77885a5a", got);
        end
    endtask

    task automatic test_reset_mid_wait();
        int ac; int waited; logic rdy; logic accepted; logic [31:0] got;
        do_req(2, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, ac, got);
        req_we[2] = 1'b1; req_addr[2] = 32'h20; req_wdata[2] = 32'h12345678; req_be[2] = 4'hF;
        req_valid[2] = 1'b1;
        accepted = 1'b0;
        waited = 0;
        while (!accepted && waited < 50) begin
            rdy = req_ready[2];
            @(posedge clk);
            #1;
            accepted = rdy;
            waited++;
        end
        req_valid[2] = 1'b0;
        checks++;
        if (!accepted) begin
            failures++;
            $display("FAIL mid_wait_accept: store not accepted within 50 cycles");
        end
        @(posedge clk);
        #1;
        rst[2] = 1'b0;
        #1;
        checks++;
        if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b0) begin
            failures++;
            $display("FAIL mid_wait_reset: rsp_valid=%b req_ready=%b, expected 0 and 0", rsp_valid[2], req_ready[2]);
        end
        @(posedge clk);
        #1;
        rst[2] = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid[2] !== 1'b0) begin
                failures++;
                $display("FAIL discarded_store_response: rsp_valid=%b, expected 0", rsp_valid[2]);
            end
        end
        do_req(2, 1'b0, 32'h20, 32'h0, 4'h0, 0, ac, got);
        checks++;
        if (got !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL mid_wait_array: rdata=%h, expected cafef00d", got);
        end
    endtask

    task automatic test_err();
        int ac; logic [31:0] got;
        do_req(0, 1'b1, 32'h0, 32'h11111111, 4'hF, 0, ac, got);
        do_req(0, 1'b0, 32'h1002, 32'h0, 4'h0, 0, ac, got);
`ifdef KAMACORE_DMEM_ERR_EN
        checks++;
        if (got !== 32'h0) begin
            failures++;
            $display("FAIL err_load_rdata: rdata=%h, expected 0", got);
        end
`endif
        do_req(0, 1'b1, 32'h1000, 32'h22222222, 4'hF, 0, ac, got);
        do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, ac, got);
`ifdef KAMACORE_DMEM_ERR_EN
        checks++;
        if (got !== 32'h11111111) begin
            failures++;
            $display("FAIL err_store_nowrite: word0=%h, expected 11111111", got);
        end
`else
        checks++;
        if (got !== 32'h22222222) begin
            failures++;
            $display("FAIL wrap_store: word0=%h, expected 22222222", got);
        end
`endif
        do_req(0, 1'b1, 32'h11, 32'h00CC0000, 4'h4, 0, ac, got);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, ac, got);
        do_req(0, 1'b1, 32'h13, 32'hEE000000, 4'h8, 0, ac, got);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, ac, got);
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_lane();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
        test_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
